bsg_clk_dly_meas_ctrl: RTL and testbench

- Reference-clock-domain sequencer that runs frequency measurements on the clock generator's monitor path.
- Per request it:
  - selects the monitor source (generated or delayed clock);
  - holds the monitor divider/counter in reset;
  - releases it for a programmed window of reference cycles;
  - captures the free-running divided-clock count with a stability check.
- Sits between the host/scan-tag command logic and the generator's mon_sel / mon_reset / div_count interface. Returns one result per request on a valid/yumi handshake.

---
 rtl/bsg_clk_dly_meas_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bsg_clk_dly_meas_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_clk_dly_meas_ctrl.sv
// Reference-clock sequencer for clock-generator monitor measurements: selects the
// monitor source, resets/releases the divider for a window, then captures a stable count.
module bsg_clk_dly_meas_ctrl #(
  parameter int count_width_p  = 8,
  parameter int window_width_p = 16,
  parameter int reset_cycles_p = 4,
  parameter int settle_cycles_p = 2,
  parameter int max_tries_p    = 7
) (
  input  logic                      clk_i,
  input  logic                      async_reset_n_i,
  input  logic                      start_v_i,
  output logic                      start_ready_o,
  input  logic                      sel_i,
  input  logic [window_width_p-1:0] window_i,
  output logic                      mon_sel_o,
  output logic                      mon_reset_o,
  input  logic [count_width_p-1:0]  div_count_i,
  output logic                      result_v_o,
  output logic [count_width_p-1:0]  result_o,
  output logic                      result_err_o,
  input  logic                      result_yumi_i,
  output logic                      busy_o
);

  localparam int phase_max_lp   = (settle_cycles_p > reset_cycles_p) ? settle_cycles_p : reset_cycles_p;
  localparam int phase_width_lp = (phase_max_lp > 1) ? $clog2(phase_max_lp) : 1;
  localparam int tries_width_lp = $clog2(max_tries_p + 1);

  localparam logic [phase_width_lp-1:0] settle_init_lp = phase_width_lp'(settle_cycles_p - 1);
  localparam logic [phase_width_lp-1:0] reset_init_lp  = phase_width_lp'(reset_cycles_p - 1);
  localparam logic [tries_width_lp-1:0] tries_last_lp  = tries_width_lp'(max_tries_p);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RESET,
    WINDOW,
    SAMPLE,
    DONE
  } state_e;

  state_e                      state_r;
  logic [1:0]                  rst_sync_r;
  logic                        rst_n;
  logic [count_width_p-1:0]    div_meta_r;
  logic [count_width_p-1:0]    div_sync_r;
  logic [count_width_p-1:0]    prev_r;
  logic [window_width_p-1:0]   window_cnt_r;
  logic [phase_width_lp-1:0]   phase_cnt_r;
  logic [tries_width_lp-1:0]   tries_r;

  // Reset asserts asynchronously but is released in step with clk_i.
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_r[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_meta_r <= '0;
      div_sync_r <= '0;
    end else begin
      div_meta_r <= div_count_i;
      div_sync_r <= div_meta_r;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mon_reset_o   <= 1'b1;
      mon_sel_o     <= 1'b0;
      result_v_o    <= 1'b0;
      result_o      <= '0;
      result_err_o  <= 1'b0;
      busy_o        <= 1'b0;
      start_ready_o <= 1'b0;
      prev_r        <= '0;
      window_cnt_r  <= '0;
      phase_cnt_r   <= '0;
      tries_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          mon_reset_o <= 1'b1;
          if (start_v_i && start_ready_o) begin
            state_r       <= SETTLE;
            mon_sel_o     <= sel_i;
            window_cnt_r  <= (window_i == '0) ? window_width_p'(1) : window_i;
            phase_cnt_r   <= settle_init_lp;
            busy_o        <= 1'b1;
            start_ready_o <= 1'b0;
          end else begin
            start_ready_o <= 1'b1;
          end
        end

        SETTLE: begin
          if (phase_cnt_r == '0) begin
            state_r     <= RESET;
            phase_cnt_r <= reset_init_lp;
          end else begin
            phase_cnt_r <= phase_cnt_r - 1'b1;
          end
        end

        RESET: begin
          if (phase_cnt_r == '0) begin
            state_r     <= WINDOW;
            mon_reset_o <= 1'b0;
          end else begin
            phase_cnt_r <= phase_cnt_r - 1'b1;
          end
        end

        // The counter is preloaded with the window length, so leaving on a value of
        // one gives exactly that many cycles with the monitor running.
        WINDOW: begin
          window_cnt_r <= window_cnt_r - 1'b1;
          if (window_cnt_r == window_width_p'(1)) begin
            state_r     <= SAMPLE;
            mon_reset_o <= 1'b1;
            tries_r     <= '0;
          end
        end

        SAMPLE: begin
          prev_r <= div_sync_r;
          if (tries_r == '0) begin
            tries_r <= tries_r + 1'b1;
          end else if (div_sync_r == prev_r) begin
            state_r      <= DONE;
            result_o     <= div_sync_r;
            result_err_o <= 1'b0;
            result_v_o   <= 1'b1;
          end else if (tries_r == tries_last_lp) begin
            state_r      <= DONE;
            result_o     <= div_sync_r;
            result_err_o <= 1'b1;
            result_v_o   <= 1'b1;
          end else begin
            tries_r <= tries_r + 1'b1;
          end
        end

        DONE: begin
          if (result_yumi_i) begin
            state_r       <= IDLE;
            result_v_o    <= 1'b0;
            busy_o        <= 1'b0;
            start_ready_o <= 1'b1;
          end
        end

        default: begin
          state_r       <= IDLE;
          mon_reset_o   <= 1'b1;
          result_v_o    <= 1'b0;
          busy_o        <= 1'b0;
          start_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_clk_dly_meas_ctrl.sv
// Directed bench for bsg_clk_dly_meas_ctrl; a behavioural model of the synchronised
// sample stream predicts each result, which is queued and checked when result_v_o rises.
module tb_bsg_clk_dly_meas_ctrl;

  localparam int max_tries_lp = 7;

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         done_cyc;
    int         low_len;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        async_reset_n_i = 1'b1;
  logic        start_v_i = 1'b0;
  logic        start_ready_o;
  logic        sel_i = 1'b0;
  logic [15:0] window_i = '0;
  logic        mon_sel_o;
  logic        mon_reset_o;
  logic [7:0]  div_count_i;
  logic        result_v_o;
  logic [7:0]  result_o;
  logic        result_err_o;
  logic        result_yumi_i = 1'b0;
  logic        busy_o;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         lowcnt = 0;
  int         cur_low = 0;
  int         last_low = 0;
  int         div_mode = 0;
  logic [7:0] const_val = '0;
  logic       count_clear = 1'b0;
  exp_t       sb[$];

  bsg_clk_dly_meas_ctrl dut (
    .clk_i           (clk_i),
    .async_reset_n_i (async_reset_n_i),
    .start_v_i       (start_v_i),
    .start_ready_o   (start_ready_o),
    .sel_i           (sel_i),
    .window_i        (window_i),
    .mon_sel_o       (mon_sel_o),
    .mon_reset_o     (mon_reset_o),
    .div_count_i     (div_count_i),
    .result_v_o      (result_v_o),
    .result_o        (result_o),
    .result_err_o    (result_err_o),
    .result_yumi_i   (result_yumi_i),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Generator stand-in: counts reference cycles seen with the monitor released.
  always @(posedge clk_i) begin
    if (count_clear) lowcnt <= 0;
    else if (!mon_reset_o) lowcnt <= lowcnt + 1;
  end

  always_comb begin
    div_count_i = const_val;
    case (div_mode)
      1:       div_count_i = 8'(lowcnt / 2);
      2:       div_count_i = cyc[0] ? 8'hAA : 8'h55;
      default: div_count_i = const_val;
    endcase
  end

  always @(negedge clk_i) begin
    if (!mon_reset_o) begin
      cur_low = cur_low + 1;
    end else if (cur_low != 0) begin
      last_low = cur_low;
      cur_low  = 0;
    end
  end

  // Value seen by the compare logic before edge a+j, after the two-flop synchroniser.
  function automatic logic [7:0] seq_val(int mode, int a, int n, logic [7:0] c, int j);
    int lc;
    if (mode == 1) begin
      lc = j - 9;
      if (lc < 0) lc = 0;
      if (lc > n) lc = n;
      return 8'(lc / 2);
    end else if (mode == 2) begin
      return (((a + j - 3) % 2) != 0) ? 8'hAA : 8'h55;
    end
    return c;
  endfunction

  function automatic exp_t model(int mode, int a, int n, logic [7:0] c);
    exp_t       e;
    logic [7:0] prev;
    logic [7:0] cur;
    prev       = seq_val(mode, a, n, c, 7 + n);
    e.res      = prev;
    e.err      = 1'b1;
    e.done_cyc = a + 7 + n + max_tries_lp;
    e.low_len  = n;
    for (int t = 1; t <= max_tries_lp; t++) begin
      cur = seq_val(mode, a, n, c, 7 + n + t);
      if (cur == prev) begin
        e.res      = cur;
        e.err      = 1'b0;
        e.done_cyc = a + 7 + n + t;
        return e;
      end
      prev  = cur;
      e.res = cur;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge; the next edge is the acceptance edge.
  task automatic applyStimulus(input logic sel, input logic [15:0] win, input int mode,
                               input logic [7:0] c, input bit push);
    int n;
    checkOutput("ready_before_start", start_ready_o, 1);
    count_clear = 1'b1;
    div_mode    = mode;
    const_val   = c;
    sel_i       = sel;
    window_i    = win;
    start_v_i   = 1'b1;
    @(posedge clk_i);
    #1;
    start_v_i   = 1'b0;
    count_clear = 1'b0;
    checkOutput("mon_sel_at_accept", mon_sel_o, sel);
    checkOutput("busy_at_accept", busy_o, 1);
    checkOutput("ready_low_when_busy", start_ready_o, 0);
    n = (win == 0) ? 1 : int'(win);
    if (push) sb.push_back(model(mode, cyc, n, c));
  endtask

  task automatic waitResult(input string tag);
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      if (result_v_o) break;
      @(posedge clk_i);
      #1;
    end
    checkOutput({tag, "_result_v"}, result_v_o, 1);
    if (result_v_o && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_result"}, result_o, e.res);
      checkOutput({tag, "_err"}, result_err_o, e.err);
      checkOutput({tag, "_latency_cyc"}, cyc, e.done_cyc);
      checkOutput({tag, "_low_len"}, last_low, e.low_len);
      checkOutput({tag, "_mon_reset_done"}, mon_reset_o, 1);
    end
  endtask

  task automatic takeResult(input string tag);
    result_yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    result_yumi_i = 1'b0;
    checkOutput({tag, "_v_dropped"}, result_v_o, 0);
    checkOutput({tag, "_idle_not_busy"}, busy_o, 0);
    checkOutput({tag, "_idle_ready"}, start_ready_o, 1);
  endtask

  initial begin
    logic       any_v;
    logic [7:0] held_res;

    #1 async_reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_mon_reset", mon_reset_o, 1);
    checkOutput("rst_mon_sel", mon_sel_o, 0);
    checkOutput("rst_result_v", result_v_o, 0);
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_err", result_err_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_ready", start_ready_o, 0);
    async_reset_n_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("idle_ready", start_ready_o, 1);

    result_yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    result_yumi_i = 1'b0;
    checkOutput("stray_yumi_v", result_v_o, 0);
    checkOutput("stray_yumi_ready", start_ready_o, 1);

    applyStimulus(1'b1, 16'd20, 1, 8'h00, 1'b1);
    waitResult("count_w20");
    checkOutput("count_w20_mon_sel", mon_sel_o, 1);
    takeResult("count_w20");
    checkOutput("mon_sel_held_after", mon_sel_o, 1);

    applyStimulus(1'b0, 16'd100, 0, 8'h5A, 1'b1);
    repeat (56) @(posedge clk_i);
    #1;
    checkOutput("mid_window_released", mon_reset_o, 0);
    #2 async_reset_n_i = 1'b0;
    #1;
    checkOutput("abort_mon_reset", mon_reset_o, 1);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_result_v", result_v_o, 0);
    checkOutput("abort_ready", start_ready_o, 0);
    checkOutput("abort_mon_sel", mon_sel_o, 0);
    void'(sb.pop_back());
    repeat (3) @(posedge clk_i);
    #1 async_reset_n_i = 1'b1;
    any_v = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk_i);
      #1;
      any_v = any_v | result_v_o;
    end
    checkOutput("abort_no_result", any_v, 0);
    checkOutput("abort_ready_again", start_ready_o, 1);

    applyStimulus(1'b0, 16'd6, 0, 8'h81, 1'b1);
    waitResult("after_abort");
    takeResult("after_abort");

    applyStimulus(1'b1, 16'd0, 0, 8'h12, 1'b1);
    waitResult("window_zero");
    takeResult("window_zero");

    applyStimulus(1'b0, 16'd4, 2, 8'h00, 1'b1);
    waitResult("toggle");
    takeResult("toggle");

    applyStimulus(1'b0, 16'd5, 0, 8'h3C, 1'b1);
    waitResult("stall");
    held_res = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_v_held", result_v_o, 1);
      checkOutput("stall_result_held", result_o, held_res);
      checkOutput("stall_ready_low", start_ready_o, 0);
      checkOutput("stall_mon_sel_held", mon_sel_o, 0);
      start_v_i = (i == 3);
      sel_i     = 1'b1;
      @(posedge clk_i);
      #1;
    end
    start_v_i = 1'b0;
    checkOutput("stall_still_busy", busy_o, 1);
    takeResult("stall");

    applyStimulus(1'b1, 16'd2, 0, 8'h77, 1'b1);
    waitResult("after_stall");
    result_yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    result_yumi_i = 1'b0;
    checkOutput("b2b_idle_v", result_v_o, 0);
    checkOutput("b2b_mon_sel_before", mon_sel_o, 1);
    applyStimulus(1'b0, 16'd3, 0, 8'h0F, 1'b1);
    waitResult("b2b");
    takeResult("b2b");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
